// File: rtl/branch_resolver_pkg.sv
// Shared sizes, the queue-entry payload and small helpers for branch_resolver.
package branch_resolver_pkg;

   localparam int unsigned DEPTH  = 16;
   localparam int unsigned IDX_W  = 4;
   localparam int unsigned ADDR_W = 32;
   localparam int unsigned CNT_W  = IDX_W + 1;

   // One in-flight conditional branch.
   typedef struct packed {
      logic              busy;
      logic              resolved;
      logic [ADDR_W-1:0] pc;
      logic              pred_taken;
      logic [ADDR_W-1:0] pred_target;
      logic              act_taken;
      logic [ADDR_W-1:0] act_target;
   } entry_t;

   // Ring pointer advance; wraps naturally modulo DEPTH.
   function automatic logic [IDX_W-1:0] idx_inc(input logic [IDX_W-1:0] idx);
      return idx + IDX_W'(1);
   endfunction

endpackage

// File: rtl/branch_mispredict_cmp.sv
// Combinational compare of predicted vs. actual outcome for a retiring branch.
//   pred_taken/pred_target : prediction made at fetch
//   act_taken/act_target   : outcome from execution
//   pc                     : branch PC (fall-through is pc+4)
//   mispredict             : direction differs, or both taken with different targets
//   redirect_pc            : correct next PC (actual target or fall-through)
module branch_mispredict_cmp
   import branch_resolver_pkg::*;
(
   input  logic              pred_taken,
   input  logic [ADDR_W-1:0] pred_target,
   input  logic              act_taken,
   input  logic [ADDR_W-1:0] act_target,
   input  logic [ADDR_W-1:0] pc,
   output logic              mispredict,
   output logic [ADDR_W-1:0] redirect_pc
);

   always_comb begin
      mispredict  = (pred_taken != act_taken) ||
                    (pred_taken && act_taken && (pred_target != act_target));
      redirect_pc = act_taken ? act_target : (pc + ADDR_W'(4));
   end

endmodule

// File: rtl/branch_resolver.sv
// In-order queue of in-flight conditional branches. Fetch pushes predicted
// branches, execution resolves them out of order by tag, and the head retires
// in program order, training the predictor and flushing on a mispredict.
//   clk, rst (async active-low), rdy (global enable)
//   IF_*  : push interface; IF_full / IF_tag are combinational from registered state
//   EX_*  : resolution by tag
//   PDC_* : one-cycle predictor training pulse per retired branch
//   flush, flush_pc : one-cycle redirect on a mispredicting retirement
module branch_resolver
   import branch_resolver_pkg::*;
(
   input  logic              clk,
   input  logic              rst,
   input  logic              rdy,
   input  logic              IF_valid,
   input  logic [ADDR_W-1:0] IF_pc,
   input  logic              IF_pred_taken,
   input  logic [ADDR_W-1:0] IF_pred_target,
   output logic              IF_full,
   output logic [IDX_W-1:0]  IF_tag,
   input  logic              EX_valid,
   input  logic [IDX_W-1:0]  EX_tag,
   input  logic              EX_taken,
   input  logic [ADDR_W-1:0] EX_target,
   output logic              PDC_valid,
   output logic              PDC_hit,
   output logic [ADDR_W-1:0] PDC_pc,
   output logic              flush,
   output logic [ADDR_W-1:0] flush_pc
);

   entry_t              ent_q [DEPTH];
   entry_t              ent_d [DEPTH];
   logic [IDX_W-1:0]    head_q, head_d;
   logic [IDX_W-1:0]    tail_q, tail_d;
   logic [CNT_W-1:0]    cnt_q, cnt_d;
   logic                pdc_valid_q, pdc_valid_d;
   logic                pdc_hit_q, pdc_hit_d;
   logic [ADDR_W-1:0]   pdc_pc_q, pdc_pc_d;
   logic                flush_q, flush_d;
   logic [ADDR_W-1:0]   flush_pc_q, flush_pc_d;

   entry_t              head_ent;
   logic                push_c;
   logic                resolve_c;
   logic                commit_c;
   logic                mispredict;
   logic [ADDR_W-1:0]   redirect_pc;

   assign head_ent = ent_q[head_q];
   assign IF_full  = (cnt_q == CNT_W'(DEPTH));
   assign IF_tag   = tail_q;

   // Inputs arriving while flush is high are wrong-path and dropped.
   assign push_c    = IF_valid && !IF_full && !flush_q;
   assign resolve_c = EX_valid && ent_q[EX_tag].busy && !ent_q[EX_tag].resolved && !flush_q;
   assign commit_c  = head_ent.busy && head_ent.resolved;

   branch_mispredict_cmp u_cmp (
      .pred_taken  (head_ent.pred_taken),
      .pred_target (head_ent.pred_target),
      .act_taken   (head_ent.act_taken),
      .act_target  (head_ent.act_target),
      .pc          (head_ent.pc),
      .mispredict  (mispredict),
      .redirect_pc (redirect_pc)
   );

   // Next-state: push / resolve / commit, or full clear on a mispredicting commit.
   always_comb begin
      for (int unsigned i = 0; i < DEPTH; i++) ent_d[i] = ent_q[i];
      head_d      = head_q;
      tail_d      = tail_q;
      cnt_d       = cnt_q;
      pdc_valid_d = 1'b0;
      pdc_hit_d   = pdc_hit_q;
      pdc_pc_d    = pdc_pc_q;
      flush_d     = 1'b0;
      flush_pc_d  = flush_pc_q;

      if (rdy) begin
         if (commit_c) begin
            pdc_valid_d = 1'b1;
            pdc_hit_d   = head_ent.act_taken;
            pdc_pc_d    = head_ent.pc;
         end

         if (commit_c && mispredict) begin
            // Everything younger than the mispredicted branch is wrong-path.
            flush_d    = 1'b1;
            flush_pc_d = redirect_pc;
            for (int unsigned i = 0; i < DEPTH; i++) ent_d[i] = '0;
            head_d = '0;
            tail_d = '0;
            cnt_d  = '0;
         end else begin
            if (resolve_c) begin
               ent_d[EX_tag].resolved   = 1'b1;
               ent_d[EX_tag].act_taken  = EX_taken;
               ent_d[EX_tag].act_target = EX_target;
            end
            if (push_c) begin
               ent_d[tail_q].busy        = 1'b1;
               ent_d[tail_q].resolved    = 1'b0;
               ent_d[tail_q].pc          = IF_pc;
               ent_d[tail_q].pred_taken  = IF_pred_taken;
               ent_d[tail_q].pred_target = IF_pred_target;
               ent_d[tail_q].act_taken   = 1'b0;
               ent_d[tail_q].act_target  = '0;
               tail_d = idx_inc(tail_q);
            end
            if (commit_c) begin
               ent_d[head_q].busy     = 1'b0;
               ent_d[head_q].resolved = 1'b0;
               head_d = idx_inc(head_q);
            end
            unique case ({push_c, commit_c})
               2'b10:   cnt_d = cnt_q + CNT_W'(1);
               2'b01:   cnt_d = cnt_q - CNT_W'(1);
               default: cnt_d = cnt_q;
            endcase
         end
      end
   end

   // State register.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         for (int unsigned i = 0; i < DEPTH; i++) ent_q[i] <= '0;
         head_q      <= '0;
         tail_q      <= '0;
         cnt_q       <= '0;
         pdc_valid_q <= 1'b0;
         pdc_hit_q   <= 1'b0;
         pdc_pc_q    <= '0;
         flush_q     <= 1'b0;
         flush_pc_q  <= '0;
      end else begin
         for (int unsigned i = 0; i < DEPTH; i++) ent_q[i] <= ent_d[i];
         head_q      <= head_d;
         tail_q      <= tail_d;
         cnt_q       <= cnt_d;
         pdc_valid_q <= pdc_valid_d;
         pdc_hit_q   <= pdc_hit_d;
         pdc_pc_q    <= pdc_pc_d;
         flush_q     <= flush_d;
         flush_pc_q  <= flush_pc_d;
      end
   end

   assign PDC_valid = pdc_valid_q;
   assign PDC_hit   = pdc_hit_q;
   assign PDC_pc    = pdc_pc_q;
   assign flush     = flush_q;
   assign flush_pc  = flush_pc_q;

endmodule

// File: tb/tb_branch_resolver.sv
// Bench for branch_resolver: directed scenarios with literal expectations plus
// randomized traffic, all outputs compared every cycle against a queue model.
module tb_branch_resolver;

   logic        clk;
   logic        rst;
   logic        rdy;
   logic        IF_valid;
   logic [31:0] IF_pc;
   logic        IF_pred_taken;
   logic [31:0] IF_pred_target;
   logic        IF_full;
   logic [3:0]  IF_tag;
   logic        EX_valid;
   logic [3:0]  EX_tag;
   logic        EX_taken;
   logic [31:0] EX_target;
   logic        PDC_valid;
   logic        PDC_hit;
   logic [31:0] PDC_pc;
   logic        flush;
   logic [31:0] flush_pc;

   int errors = 0;
   int checks = 0;

   branch_resolver dut (
      .clk            (clk),
      .rst            (rst),
      .rdy            (rdy),
      .IF_valid       (IF_valid),
      .IF_pc          (IF_pc),
      .IF_pred_taken  (IF_pred_taken),
      .IF_pred_target (IF_pred_target),
      .IF_full        (IF_full),
      .IF_tag         (IF_tag),
      .EX_valid       (EX_valid),
      .EX_tag         (EX_tag),
      .EX_taken       (EX_taken),
      .EX_target      (EX_target),
      .PDC_valid      (PDC_valid),
      .PDC_hit        (PDC_hit),
      .PDC_pc         (PDC_pc),
      .flush          (flush),
      .flush_pc       (flush_pc)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // ---------------- reference model: program-ordered list of branches ----------
   typedef struct {
      int          tag;
      logic [31:0] pc;
      logic        pt;
      logic [31:0] ptg;
      logic        res;
      logic        at;
      logic [31:0] atg;
   } m_ent_t;

   m_ent_t      mq[$];
   int          m_tail = 0;
   logic        e_pv = 1'b0;
   logic        e_hit = 1'b0;
   logic [31:0] e_pc = '0;
   logic        e_fl = 1'b0;
   logic [31:0] e_fpc = '0;
   logic        m_was_fl;
   logic        m_com;
   m_ent_t      m_h;
   m_ent_t      m_new;

   always @(posedge clk or negedge rst) begin
      if (!rst) begin
         mq.delete();
         m_tail = 0;
         e_pv = 1'b0; e_hit = 1'b0; e_pc = '0; e_fl = 1'b0; e_fpc = '0;
      end else if (!rdy) begin
         e_pv = 1'b0;
         e_fl = 1'b0;
      end else begin
         m_was_fl = e_fl;
         m_com = (mq.size() > 0) && mq[0].res;
         e_pv = 1'b0;
         e_fl = 1'b0;
         if (m_com) begin
            m_h   = mq[0];
            e_pv  = 1'b1;
            e_hit = m_h.at;
            e_pc  = m_h.pc;
            if ((m_h.pt != m_h.at) || (m_h.pt && m_h.at && m_h.ptg != m_h.atg)) begin
               e_fl  = 1'b1;
               e_fpc = m_h.at ? m_h.atg : m_h.pc + 32'd4;
               mq.delete();
               m_tail = 0;
            end
         end
         if (!e_fl) begin
            if (!m_was_fl && EX_valid) begin
               for (int i = 0; i < mq.size(); i++) begin
                  if (mq[i].tag == int'(EX_tag) && !mq[i].res) begin
                     mq[i].res = 1'b1;
                     mq[i].at  = EX_taken;
                     mq[i].atg = EX_target;
                  end
               end
            end
            if (!m_was_fl && IF_valid && mq.size() < 16) begin
               m_new.tag = m_tail;
               m_new.pc  = IF_pc;
               m_new.pt  = IF_pred_taken;
               m_new.ptg = IF_pred_target;
               m_new.res = 1'b0;
               m_new.at  = 1'b0;
               m_new.atg = '0;
               mq.push_back(m_new);
               m_tail = (m_tail + 1) % 16;
            end
            if (m_com) void'(mq.pop_front());
         end
      end
   end

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s at %0t: got %h expected %h", name, $time, act, exp);
      end
   endtask

   // ---------------- per-cycle compare against the model ------------------------
   always @(negedge clk) begin
      chk("IF_full",   32'(IF_full),   32'(mq.size() == 16));
      chk("IF_tag",    32'(IF_tag),    32'(m_tail));
      chk("PDC_valid", 32'(PDC_valid), 32'(e_pv));
      chk("PDC_hit",   32'(PDC_hit),   32'(e_hit));
      chk("PDC_pc",    PDC_pc,         e_pc);
      chk("flush",     32'(flush),     32'(e_fl));
      chk("flush_pc",  flush_pc,       e_fpc);
   end

   // ---------------- stimulus helpers -------------------------------------------
   task automatic cyc();
      @(posedge clk);
      @(negedge clk);
      #1;
   endtask

   task automatic idle();
      IF_valid = 1'b0; EX_valid = 1'b0;
   endtask

   task automatic push(input logic [31:0] pc, input logic pt, input logic [31:0] tgt);
      IF_valid = 1'b1; IF_pc = pc; IF_pred_taken = pt; IF_pred_target = tgt;
   endtask

   task automatic resolve(input logic [3:0] tag, input logic tk, input logic [31:0] tgt);
      EX_valid = 1'b1; EX_tag = tag; EX_taken = tk; EX_target = tgt;
   endtask

   int pick;

   initial begin
      rst = 1'b1; rdy = 1'b1;
      IF_valid = 1'b0; IF_pc = '0; IF_pred_taken = 1'b0; IF_pred_target = '0;
      EX_valid = 1'b0; EX_tag = '0; EX_taken = 1'b0; EX_target = '0;
      #1 rst = 1'b0;
      cyc(); cyc();
      chk("rst_PDC_valid", 32'(PDC_valid), 32'd0);
      chk("rst_flush", 32'(flush), 32'd0);
      chk("rst_IF_tag", 32'(IF_tag), 32'd0);
      rst = 1'b1;
      cyc();

      // Correctly predicted taken branch.
      push(32'h100, 1'b1, 32'h140);
      chk("d1_tag", 32'(IF_tag), 32'd0);
      cyc(); idle(); resolve(4'd0, 1'b1, 32'h140);
      cyc(); idle();
      cyc();
      chk("d1_pv", 32'(PDC_valid), 32'd1);
      chk("d1_hit", 32'(PDC_hit), 32'd1);
      chk("d1_pc", PDC_pc, 32'h100);
      chk("d1_fl", 32'(flush), 32'd0);
      cyc();
      chk("d1_pv_drop", 32'(PDC_valid), 32'd0);

      // Direction mispredict; push during flush cycle is dropped.
      push(32'h200, 1'b1, 32'h240);
      chk("d2_tag", 32'(IF_tag), 32'd1);
      cyc(); idle(); resolve(4'd1, 1'b0, 32'h0);
      cyc(); idle();
      cyc();
      chk("d2_pv", 32'(PDC_valid), 32'd1);
      chk("d2_hit", 32'(PDC_hit), 32'd0);
      chk("d2_fl", 32'(flush), 32'd1);
      chk("d2_fpc", flush_pc, 32'h204);
      push(32'h300, 1'b0, 32'h308);
      cyc(); idle();
      chk("d2_drop_tag", 32'(IF_tag), 32'd0);
      chk("d2_fl_drop", 32'(flush), 32'd0);

      // Out-of-order resolution, in-order retirement.
      for (int k = 0; k < 3; k++) begin
         push(32'h400 + 32'(k * 4), 1'b0, 32'h480);
         cyc();
      end
      idle(); resolve(4'd2, 1'b0, 32'h0); cyc();
      chk("d3_wait", 32'(PDC_valid), 32'd0);
      resolve(4'd0, 1'b0, 32'h0); cyc();
      chk("d3_wait2", 32'(PDC_valid), 32'd0);
      resolve(4'd1, 1'b0, 32'h0); cyc();
      chk("d3_c0", PDC_pc, 32'h400);
      idle(); cyc();
      chk("d3_c1", PDC_pc, 32'h404);
      chk("d3_c1v", 32'(PDC_valid), 32'd1);
      cyc();
      chk("d3_c2", PDC_pc, 32'h408);
      chk("d3_c2v", 32'(PDC_valid), 32'd1);

      // Fill to 16 with wrap of the tail pointer.
      for (int k = 0; k < 16; k++) begin
         push(32'h500 + 32'(k * 4), 1'b0, 32'h5f0);
         cyc();
      end
      chk("d4_full", 32'(IF_full), 32'd1);
      chk("d4_tag", 32'(IF_tag), 32'd3);
      push(32'hbad0, 1'b0, 32'h0); cyc();
      chk("d4_17th", 32'(IF_tag), 32'd3);
      idle(); resolve(4'd3, 1'b0, 32'h0); cyc();
      resolve(4'd4, 1'b0, 32'h0); cyc();
      chk("d4_c3", PDC_pc, 32'h500);
      idle(); push(32'h600, 1'b0, 32'h0); cyc();
      chk("d4_pc_both", PDC_pc, 32'h504);
      chk("d4_notfull", 32'(IF_full), 32'd0);
      push(32'h604, 1'b0, 32'h0); cyc();
      chk("d4_refull", 32'(IF_full), 32'd1);
      chk("d4_tag5", 32'(IF_tag), 32'd5);

      // rdy low freezes a resolved head.
      idle(); resolve(4'd5, 1'b0, 32'h0); cyc();
      idle(); rdy = 1'b0;
      cyc(); chk("d5_frz1", 32'(PDC_valid), 32'd0);
      cyc(); chk("d5_frz2", 32'(PDC_valid), 32'd0);
      rdy = 1'b1; cyc();
      chk("d5_go", 32'(PDC_valid), 32'd1);
      chk("d5_pc", PDC_pc, 32'h508);

      // Reset mid-stream with many entries busy.
      rst = 1'b0; cyc();
      chk("d6_full", 32'(IF_full), 32'd0);
      chk("d6_tag", 32'(IF_tag), 32'd0);
      chk("d6_pc", PDC_pc, 32'd0);
      chk("d6_fpc", flush_pc, 32'd0);
      rst = 1'b1; push(32'h700, 1'b1, 32'h710);
      chk("d6_push_tag", 32'(IF_tag), 32'd0);
      cyc(); idle();
      chk("d6_tag1", 32'(IF_tag), 32'd1);

      // Randomized traffic.
      for (int n = 0; n < 4000; n++) begin
         rdy = ($urandom_range(0, 9) != 0);
         IF_valid = ($urandom_range(0, 2) != 0);
         IF_pc = 32'($urandom_range(0, 1023)) << 2;
         IF_pred_taken = 1'($urandom);
         IF_pred_target = IF_pc + 32'($urandom_range(1, 8) * 4);
         EX_valid = 1'($urandom);
         EX_taken = 1'($urandom);
         EX_target = 32'($urandom_range(0, 1023)) << 2;
         if (mq.size() > 0 && $urandom_range(0, 3) != 0) begin
            pick = int'($urandom_range(0, mq.size() - 1));
            EX_tag = 4'(mq[pick].tag);
            if ($urandom_range(0, 9) < 8) EX_taken = mq[pick].pt;
            if ($urandom_range(0, 9) < 8) EX_target = mq[pick].ptg;
         end else begin
            EX_tag = 4'($urandom);
         end
         if ($urandom_range(0, 799) == 0) rst = 1'b0;
         cyc();
         rst = 1'b1;
      end

      idle();
      cyc();
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
